frequency_divider_ctrl: RTL and testbench

Run controller for the frequency divider. It owns the terminal-count counter and turns a 2-bit speed select into a periodic one-cycle `tick` enable. It accepts speed changes through a valid/ready handshake and applies them only at a period boundary, so no truncated or stretched period appears. It also supports run/pause, single-step while paused, and clear. It sits between user controls (switches/keys, synchronised upstream) and every downstream block clocked by `tick` enables.

---
 rtl/freq_div_pkg.sv | 25 ++
 rtl/terminal_counter.sv | 31 +++
 rtl/frequency_divider_ctrl.sv | 147 ++++++++++++++
 tb/tb_frequency_divider_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/freq_div_pkg.sv
// Shared types, constants and helpers for the frequency divider run controller.
package freq_div_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StPause = 2'd2
  } state_t;

  localparam int unsigned COUNT_W = 26;

  localparam int unsigned PERIOD_0 = 1;
  localparam int unsigned PERIOD_1 = 12_500_000;
  localparam int unsigned PERIOD_2 = 25_000_000;
  localparam int unsigned PERIOD_3 = 50_000_000;

  // periods[s] is the tick period in clocks for speed code s.
  function automatic logic [COUNT_W-1:0] reload_value(input logic [1:0]        speed,
                                                      input logic [3:0][31:0] periods);
    logic [31:0] r;
    r = periods[speed] - 32'd1;
    return r[COUNT_W-1:0];
  endfunction

endpackage

// File: rtl/terminal_counter.sv
// Loadable down-counter that stops at zero; load has priority over decrement.
module terminal_counter
  import freq_div_pkg::*;
#(
  parameter logic [COUNT_W-1:0] RESET_VALUE = '0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic [COUNT_W-1:0] load_value,
  input  logic               enable,
  output logic [COUNT_W-1:0] count,
  output logic               zero
);

  logic [COUNT_W-1:0] count_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= RESET_VALUE;
    end else if (load) begin
      count_q <= load_value;
    end else if (enable && !zero) begin
      count_q <= count_q - COUNT_W'(1);
    end
  end

  assign count = count_q;
  assign zero  = (count_q == '0);

endmodule

// File: rtl/frequency_divider_ctrl.sv
// Run controller: turns a speed code into a periodic one-cycle tick, with run/pause/step/clear
// and speed changes deferred to a period boundary.
module frequency_divider_ctrl #(
  parameter int unsigned PERIOD_0    = freq_div_pkg::PERIOD_0,
  parameter int unsigned PERIOD_1    = freq_div_pkg::PERIOD_1,
  parameter int unsigned PERIOD_2    = freq_div_pkg::PERIOD_2,
  parameter int unsigned PERIOD_3    = freq_div_pkg::PERIOD_3,
  parameter logic [1:0]  RESET_SPEED = 2'b11
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] speed,
  input  logic       speed_valid,
  output logic       speed_ready,
  input  logic       run,
  input  logic       step,
  input  logic       clear,
  output logic       tick,
  output logic [1:0] active_speed,
  output logic [1:0] state
);

  import freq_div_pkg::*;

  localparam int unsigned MaxPeriod = 32'd1 << COUNT_W;
  localparam logic [3:0][31:0] Periods = {32'(PERIOD_3), 32'(PERIOD_2),
                                          32'(PERIOD_1), 32'(PERIOD_0)};
  localparam logic [COUNT_W-1:0] ResetReload = reload_value(RESET_SPEED, Periods);

  if (PERIOD_0 < 1 || PERIOD_0 > MaxPeriod || PERIOD_1 < 1 || PERIOD_1 > MaxPeriod ||
      PERIOD_2 < 1 || PERIOD_2 > MaxPeriod || PERIOD_3 < 1 || PERIOD_3 > MaxPeriod) begin : g_bad
    $error("frequency_divider_ctrl: every period must lie in 1..2^26");
  end

  state_t             state_q, state_d;
  logic [1:0]         active_q, active_d;
  logic [1:0]         pending_speed_q, pending_speed_d;
  logic               pending_valid_q, pending_valid_d;
  logic               tick_q, tick_d;
  logic               accept, apply;
  logic               cnt_load, cnt_enable, cnt_zero;
  logic [1:0]         eff_speed;
  logic [COUNT_W-1:0] cnt_load_value;
  logic [COUNT_W-1:0] count;

  terminal_counter #(
    .RESET_VALUE (ResetReload)
  ) u_counter (
    .clock      (clock),
    .reset      (reset),
    .load       (cnt_load),
    .load_value (cnt_load_value),
    .enable     (cnt_enable),
    .count      (count),
    .zero       (cnt_zero)
  );

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= StIdle;
      active_q        <= RESET_SPEED;
      pending_speed_q <= RESET_SPEED;
      pending_valid_q <= 1'b0;
      tick_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      active_q        <= active_d;
      pending_speed_q <= pending_speed_d;
      pending_valid_q <= pending_valid_d;
      tick_q          <= tick_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:  if (run)  state_d = StRun;
        StRun:   if (!run) state_d = StPause;
        StPause: if (run)  state_d = StRun;
        default: state_d = StIdle;
      endcase
    end
  end

  // Datapath: every reload uses the pending speed if one is waiting, since it applies that cycle.
  always_comb begin
    eff_speed      = pending_valid_q ? pending_speed_q : active_q;
    cnt_load_value = reload_value(eff_speed, Periods);
    cnt_load       = 1'b0;
    cnt_enable     = 1'b0;
    apply          = 1'b0;
    tick_d         = 1'b0;
    if (clear) begin
      apply    = pending_valid_q;
      cnt_load = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          apply    = pending_valid_q;
          cnt_load = pending_valid_q;
        end
        StRun: begin
          if (cnt_zero) begin
            tick_d   = 1'b1;
            cnt_load = 1'b1;
            apply    = pending_valid_q;
          end else begin
            cnt_enable = 1'b1;
          end
        end
        StPause: begin
          apply    = pending_valid_q;
          cnt_load = pending_valid_q;
          if (!run && step) begin
            tick_d   = 1'b1;
            cnt_load = 1'b1;
          end
        end
        default: ;
      endcase
    end

    accept          = speed_valid && speed_ready;
    active_d        = apply ? pending_speed_q : active_q;
    pending_valid_d = apply ? 1'b0 : pending_valid_q;
    pending_speed_d = pending_speed_q;
    // Accept only happens with nothing pending, so it never collides with an apply.
    if (accept) begin
      pending_speed_d = speed;
      pending_valid_d = 1'b1;
    end
  end

  // Outputs
  always_comb begin
    speed_ready  = !pending_valid_q && !reset;
    tick         = tick_q;
    active_speed = active_q;
    state        = state_q;
  end

endmodule

// File: tb/tb_frequency_divider_ctrl.sv
// Directed bench for frequency_divider_ctrl with periods 1/4/8/16 and reset speed 3.
module tb_frequency_divider_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] speed;
  logic       speed_valid;
  logic       speed_ready;
  logic       run;
  logic       step;
  logic       clear;
  logic       tick;
  logic [1:0] active_speed;
  logic [1:0] state;

  int compared   = 0;
  int mismatched = 0;
  int n;

  frequency_divider_ctrl #(
    .PERIOD_0    (1),
    .PERIOD_1    (4),
    .PERIOD_2    (8),
    .PERIOD_3    (16),
    .RESET_SPEED (2'b11)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .speed        (speed),
    .speed_valid  (speed_valid),
    .speed_ready  (speed_ready),
    .run          (run),
    .step         (step),
    .clear        (clear),
    .tick         (tick),
    .active_speed (active_speed),
    .state        (state)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Advance n rising edges, leaving time 1 unit past the last edge.
  task automatic cyc(input int cycles);
    repeat (cycles) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Edges until tick is seen high, bounded by max.
  task automatic wait_tick(input int max, output int edges);
    edges = 0;
    do begin
      cyc(1);
      edges++;
    end while (tick !== 1'b1 && edges < max);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; speed = 2'b00; speed_valid = 1'b0;
    run = 1'b0; step = 1'b0; clear = 1'b0;
    cyc(2);
    chk("ready_low_in_reset", speed_ready, 0);
    reset = 1'b0;
    #1;
    chk("reset_state", state, 0);
    chk("reset_active", active_speed, 3);
    chk("reset_tick", tick, 0);
    chk("reset_count", dut.u_counter.count, 15);
    chk("reset_ready", speed_ready, 1);

    // Reset and run: first tick 17 edges after run is set up, then every 16
    run = 1'b1;
    wait_tick(40, n);
    chk("first_tick_latency", n, 17);
    wait_tick(40, n);
    chk("speed3_spacing", n, 16);
    chk("speed3_active", active_speed, 3);

    // Speed change mid-period: old 16-cycle period completes (count 12 -> 11 at accept)
    cyc(3);
    speed = 2'b01; speed_valid = 1'b1;
    cyc(1);
    speed_valid = 1'b0;
    chk("ready_drops_after_accept", speed_ready, 0);
    chk("active_unchanged_while_pending", active_speed, 3);
    wait_tick(40, n);
    chk("old_period_completes", n, 12);
    chk("new_speed_applied", active_speed, 1);
    chk("ready_back_after_apply", speed_ready, 1);
    wait_tick(40, n);
    chk("speed1_spacing_a", n, 4);
    wait_tick(40, n);
    chk("speed1_spacing_b", n, 4);

    // Move to speed 2, then pause after 5 RUN edges
    speed = 2'b10; speed_valid = 1'b1;
    cyc(1);
    speed_valid = 1'b0;
    wait_tick(40, n);
    chk("speed1_to_2_boundary", n, 3);
    chk("speed2_active", active_speed, 2);
    cyc(4);
    run = 1'b0;
    cyc(1);
    chk("paused_state", state, 2);
    chk("paused_count", dut.u_counter.count, 2);
    cyc(20);
    chk("count_holds_in_pause", dut.u_counter.count, 2);
    chk("no_tick_in_pause", tick, 0);
    run = 1'b1;
    wait_tick(40, n);
    // one edge to re-enter RUN, then 3 RUN edges
    chk("resume_tick", n, 4);

    // Step while paused
    cyc(2);
    run = 1'b0;
    cyc(1);
    chk("pause_before_step", dut.u_counter.count, 4);
    step = 1'b1;
    cyc(1);
    step = 1'b0;
    chk("step_tick", tick, 1);
    chk("step_reload", dut.u_counter.count, 7);
    chk("step_stays_paused", state, 2);
    cyc(1);
    chk("step_tick_one_cycle", tick, 0);
    step = 1'b1; run = 1'b1;
    cyc(1);
    step = 1'b0;
    chk("step_with_run_no_tick", tick, 0);
    chk("step_with_run_state", state, 1);
    chk("step_with_run_count", dut.u_counter.count, 7);
    wait_tick(40, n);
    chk("full_period_after_resume", n, 8);

    // Speed 0: tick continuously high
    speed = 2'b00; speed_valid = 1'b1;
    cyc(1);
    speed_valid = 1'b0;
    wait_tick(40, n);
    chk("speed2_to_0_boundary", n, 7);
    chk("speed0_active", active_speed, 0);
    cyc(1);
    chk("speed0_tick_a", tick, 1);
    cyc(3);
    chk("speed0_tick_b", tick, 1);
    clear = 1'b1; run = 1'b0;
    cyc(1);
    clear = 1'b0;
    chk("clear_tick", tick, 0);
    chk("clear_state", state, 0);

    // Back-to-back requests in IDLE: second one held off until first applies
    speed = 2'b10; speed_valid = 1'b1;
    cyc(1);
    chk("b2b_first_pending", speed_ready, 0);
    speed = 2'b01;
    cyc(1);
    chk("b2b_first_applied", active_speed, 2);
    chk("b2b_first_count", dut.u_counter.count, 7);
    chk("b2b_ready_again", speed_ready, 1);
    cyc(1);
    speed_valid = 1'b0;
    chk("b2b_second_pending", speed_ready, 0);
    chk("b2b_second_not_yet", active_speed, 2);
    cyc(1);
    chk("b2b_second_applied", active_speed, 1);
    chk("b2b_second_count", dut.u_counter.count, 3);

    // Reset while a request is pending
    run = 1'b1;
    cyc(1);
    speed = 2'b00; speed_valid = 1'b1;
    cyc(1);
    speed_valid = 1'b0;
    chk("pending_before_reset", dut.pending_valid_q, 1);
    reset = 1'b1;
    cyc(1);
    chk("reset_clears_pending", dut.pending_valid_q, 0);
    chk("reset_active_speed", active_speed, 3);
    chk("reset_mid_tick", tick, 0);
    chk("reset_mid_state", state, 0);
    chk("reset_mid_count", dut.u_counter.count, 15);
    reset = 1'b0;
    run = 1'b0;
    #1;
    chk("ready_after_reset", speed_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
